// File: rtl/cpu_hazard_ctrl.sv
// Issue/stall/flush control for a single-issue pipeline.
// It keeps a per-register pending-write scoreboard and runs a two-cycle branch-flush sequencer.
module cpu_hazard_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dec_valid_i,
  input  logic        dec_useA_i,
  input  logic        dec_useB_i,
  input  logic [3:0]  dec_riA_i,
  input  logic [3:0]  dec_riB_i,
  input  logic        dec_wa_i,
  input  logic        dec_wb_i,
  input  logic [3:0]  dec_w0_idx_i,
  input  logic [3:0]  dec_w1_idx_i,
  input  logic        ex_busy_i,
  input  logic        branch_flag_i,
  input  logic        wb_wea_i,
  input  logic        wb_web_i,
  input  logic [3:0]  wb_idx0_i,
  input  logic [3:0]  wb_idx1_i,
  output logic        issue_o,
  output logic        stall_o,
  output logic        bubble_o,
  output logic        flush_o,
  output logic [15:0] pending_o
);

  typedef enum logic [1:0] {RUN, FLUSH0, FLUSH1} state_e;

  state_e      state_q, state_d;
  logic        flush_q, flush_d;
  logic [1:0]  cnt_q [16];
  logic [1:0]  cnt_d [16];
  logic [15:0] pending_q, pending_d;
  logic [15:0] inc_vec, dec_vec;
  logic        raw_hazard, waw_hazard, in_run;

  // Hazards look only at registered counts, so a same-cycle retire never bypasses.
  assign raw_hazard = (dec_useA_i && (cnt_q[dec_riA_i] != 2'd0)) ||
                      (dec_useB_i && (cnt_q[dec_riB_i] != 2'd0));
  assign waw_hazard = (dec_wa_i && (cnt_q[dec_w0_idx_i] == 2'd3)) ||
                      (dec_wb_i && (cnt_q[dec_w1_idx_i] == 2'd3));
  assign in_run     = (state_q == RUN);

  assign issue_o   = dec_valid_i && in_run && !ex_busy_i && !branch_flag_i &&
                     !raw_hazard && !waw_hazard;
  assign stall_o   = dec_valid_i && !issue_o && in_run;
  assign bubble_o  = !issue_o;
  assign flush_o   = flush_q;
  assign pending_o = pending_q;

  // One-hot increment/decrement requests; a duplicated index collapses to a single step.
  always_comb begin
    for (int r = 0; r < 16; r++) begin
      inc_vec[r] = issue_o && ((dec_wa_i && (dec_w0_idx_i == 4'(r))) ||
                               (dec_wb_i && (dec_w1_idx_i == 4'(r))));
      dec_vec[r] = (wb_wea_i && (wb_idx0_i == 4'(r))) ||
                   (wb_web_i && (wb_idx1_i == 4'(r)));
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch can be inferred.
    pending_d = '0;
    for (int r = 0; r < 16; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_vec[r] && !dec_vec[r] && (cnt_q[r] != 2'd3)) begin
        cnt_d[r] = cnt_q[r] + 2'd1;
      end else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != 2'd0)) begin
        cnt_d[r] = cnt_q[r] - 2'd1;
      end
      pending_d[r] = (cnt_d[r] != 2'd0);
    end
  end

  always_comb begin
    state_d = state_q;
    if (branch_flag_i) begin
      state_d = FLUSH0;
    end else begin
      case (state_q)
        FLUSH0:  state_d = FLUSH1;
        FLUSH1:  state_d = RUN;
        default: state_d = RUN;
      endcase
    end
    flush_d = (state_d != RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

  // NOTE: the scoreboard array is reset explicitly; in-flight writes are discarded on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < 16; r++) cnt_q[r] <= 2'd0;
      pending_q <= '0;
    end else begin
      for (int r = 0; r < 16; r++) cnt_q[r] <= cnt_d[r];
      pending_q <= pending_d;
    end
  end

endmodule
